// File: rtl/issue_scheduler_if.sv
// Decode, execute, branch/LSU feedback and write-back signals for the issue scheduler.
// The slave modport is the scheduler; the master modport is whoever drives it.
interface issue_scheduler_if #(
    parameter int STALL_W = 16
);
    logic               dec_valid;
    logic               dec_ready;
    logic [5:0]         dec_type;
    logic               dec_is_load;
    logic [4:0]         dec_rd;
    logic [4:0]         dec_rs1;
    logic [4:0]         dec_rs2;
    logic               exu_valid;
    logic [2:0]         exu_sel;
    logic [4:0]         exu_rd;
    logic               br_resolve;
    logic               br_taken;
    logic               lsu_done;
    logic               wb_valid;
    logic [4:0]         wb_rd;
    logic               flush;
    logic [STALL_W-1:0] stall_cycles;

    modport master (
        output dec_valid, dec_type, dec_is_load, dec_rd, dec_rs1, dec_rs2,
        output br_resolve, br_taken, lsu_done, wb_valid, wb_rd,
        input  dec_ready, exu_valid, exu_sel, exu_rd, flush, stall_cycles
    );

    modport slave (
        input  dec_valid, dec_type, dec_is_load, dec_rd, dec_rs1, dec_rs2,
        input  br_resolve, br_taken, lsu_done, wb_valid, wb_rd,
        output dec_ready, exu_valid, exu_sel, exu_rd, flush, stall_cycles
    );
endinterface

// File: rtl/issue_scheduler.sv
// Single-entry in-order issue stage with a register busy scoreboard and
// blocking waits on branch resolution and load/store completion.
module issue_scheduler #(
    parameter int STALL_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    issue_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_BR, WAIT_LSU, FLUSH} state_t;

    state_t             state_q, state_d;
    logic               buf_full_q, buf_full_d;
    logic [5:0]         type_q, type_d;
    logic               load_q, load_d;
    logic [4:0]         rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [31:0]        busy_q, busy_d;
    logic               exu_valid_q, exu_valid_d;
    logic [2:0]         exu_sel_q, exu_sel_d;
    logic [4:0]         exu_rd_q, exu_rd_d;
    logic               flush_q, flush_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic t_r, t_i, t_s, t_b, t_u, t_j;
    logic uses_rs1, uses_rs2, writes_rd, set_busy;
    logic sel_alu, sel_bu, sel_lsu;
    logic hazard, can_issue, dec_ready, accept;

    // Decode of the buffered instruction; dec_type is {r,i,s,b,u,j}.
    assign {t_r, t_i, t_s, t_b, t_u, t_j} = type_q;
    assign uses_rs1  = t_r | t_i | t_s | t_b;
    assign uses_rs2  = t_r | t_s | t_b;
    assign writes_rd = (t_r | t_i | t_u | t_j) & (rd_q != 5'd0);
    assign sel_alu   = t_r | (t_i & ~load_q);
    assign sel_bu    = t_b | t_j;
    assign sel_lsu   = t_s | (t_i & load_q);

    assign hazard    = (uses_rs1 & busy_q[rs1_q]) | (uses_rs2 & busy_q[rs2_q]);
    assign can_issue = buf_full_q & (state_q == IDLE) & ~hazard;
    assign dec_ready = (state_q != FLUSH) & (~buf_full_q | can_issue);
    assign accept    = bus.dec_valid & dec_ready;
    assign set_busy  = can_issue & writes_rd;

    // A set from a fresh issue wins over a same-edge write-back clear.
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            assign busy_d[gi] = 1'b0;
        end else begin : g_reg
            assign busy_d[gi] = (set_busy & (rd_q == 5'(gi))) |
                                (busy_q[gi] & ~(bus.wb_valid & (bus.wb_rd == 5'(gi))));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            buf_full_q  <= 1'b0;
            type_q      <= '0;
            load_q      <= 1'b0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            busy_q      <= '0;
            exu_valid_q <= 1'b0;
            exu_sel_q   <= '0;
            exu_rd_q    <= '0;
            flush_q     <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            buf_full_q  <= buf_full_d;
            type_q      <= type_d;
            load_q      <= load_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            busy_q      <= busy_d;
            exu_valid_q <= exu_valid_d;
            exu_sel_q   <= exu_sel_d;
            exu_rd_q    <= exu_rd_d;
            flush_q     <= flush_d;
            stall_q     <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (can_issue && sel_bu)       state_d = WAIT_BR;
                else if (can_issue && sel_lsu) state_d = WAIT_LSU;
            end
            WAIT_BR:  if (bus.br_resolve) state_d = bus.br_taken ? FLUSH : IDLE;
            WAIT_LSU: if (bus.lsu_done)   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        buf_full_d = buf_full_q;
        type_d     = type_q;
        load_d     = load_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        // A taken branch squashes whatever was buffered behind it.
        if (state_q == FLUSH) begin
            buf_full_d = 1'b0;
        end else if (accept) begin
            buf_full_d = 1'b1;
            type_d     = bus.dec_type;
            load_d     = bus.dec_is_load;
            rd_d       = bus.dec_rd;
            rs1_d      = bus.dec_rs1;
            rs2_d      = bus.dec_rs2;
        end else if (can_issue) begin
            buf_full_d = 1'b0;
        end

        exu_valid_d = can_issue;
        exu_sel_d   = can_issue ? {sel_alu, sel_bu, sel_lsu} : 3'b000;
        exu_rd_d    = can_issue ? rd_q : 5'd0;
        flush_d     = (state_d == FLUSH);

        stall_d = stall_q;
        if (buf_full_q && (state_q == IDLE) && hazard && (stall_q != {STALL_W{1'b1}}))
            stall_d = stall_q + 1'b1;
    end

    assign bus.dec_ready    = dec_ready;
    assign bus.exu_valid    = exu_valid_q;
    assign bus.exu_sel      = exu_sel_q;
    assign bus.exu_rd       = exu_rd_q;
    assign bus.flush        = flush_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// Random-stimulus bench for issue_scheduler: a rule-level reference model predicts
// issues into a queue that an independent monitor drains against the DUT.
module tb_issue_scheduler;
    localparam int SW      = 4;
    localparam int STALL_MAX = (1 << SW) - 1;
    localparam int CYCLES  = 1500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_scheduler_if #(.STALL_W(SW)) bus ();
    issue_scheduler #(.STALL_W(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    int issues_seen = 0;

    typedef struct {int sel; int rd;} exp_t;
    exp_t exp_q[$];

    // Reference model. Types: 0=r 1=i 2=s 3=b 4=u 5=j. Modes: 0 idle, 1 branch wait, 2 lsu wait, 3 flush.
    int m_mode = 0;
    bit m_full = 0;
    int m_t, m_rd, m_rs1, m_rs2;
    bit m_ld;
    bit m_busy[32];
    int m_stall = 0;
    bit m_flush = 0;
    int cur_t = 0;

    function automatic bit reads_rs1(int t); return t <= 3; endfunction
    function automatic bit reads_rs2(int t); return t == 0 || t == 2 || t == 3; endfunction
    function automatic bit writes(int t); return t == 0 || t == 1 || t == 4 || t == 5; endfunction
    function automatic bit is_branch(int t); return t == 3 || t == 5; endfunction
    function automatic bit is_mem(int t, bit ld); return t == 2 || (t == 1 && ld); endfunction
    function automatic int sel_of(int t, bit ld);
        if (t == 0 || (t == 1 && !ld)) return 4;
        if (is_branch(t)) return 2;
        if (is_mem(t, ld)) return 1;
        return 0;
    endfunction

    function automatic bit m_hazard();
        return m_full && ((reads_rs1(m_t) && m_busy[m_rs1]) || (reads_rs2(m_t) && m_busy[m_rs2]));
    endfunction
    function automatic bit m_can_issue();
        return m_full && m_mode == 0 && !m_hazard();
    endfunction
    function automatic bit m_ready();
        return m_mode != 3 && (!m_full || m_can_issue());
    endfunction

    task automatic model_reset();
        m_mode = 0; m_full = 0; m_stall = 0; m_flush = 0;
        foreach (m_busy[i]) m_busy[i] = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit iss, rdy, hz;
        int nmode;
        hz  = m_hazard();
        iss = m_can_issue();
        rdy = m_ready();
        if (m_full && m_mode == 0 && hz && m_stall < STALL_MAX) m_stall++;
        m_flush = 0;
        nmode = m_mode;
        case (m_mode)
            0: if (iss) nmode = is_branch(m_t) ? 1 : (is_mem(m_t, m_ld) ? 2 : 0);
            1: if (bus.br_resolve) begin nmode = bus.br_taken ? 3 : 0; m_flush = bus.br_taken; end
            2: if (bus.lsu_done) nmode = 0;
            default: nmode = 0;
        endcase
        if (bus.wb_valid) m_busy[bus.wb_rd] = 0;
        if (iss) begin
            exp_q.push_back('{sel_of(m_t, m_ld), m_rd});
            if (writes(m_t) && m_rd != 0) m_busy[m_rd] = 1;
        end
        if (m_mode == 3) m_full = 0;
        else if (rdy && bus.dec_valid) begin
            m_full = 1; m_t = cur_t; m_ld = bus.dec_is_load;
            m_rd = int'(bus.dec_rd); m_rs1 = int'(bus.dec_rs1); m_rs2 = int'(bus.dec_rs2);
        end else if (iss) m_full = 0;
        m_mode = nmode;
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_exu_valid"}, int'(bus.exu_valid), 0);
        check({tag, "_exu_sel"}, int'(bus.exu_sel), 0);
        check({tag, "_exu_rd"}, int'(bus.exu_rd), 0);
        check({tag, "_flush"}, int'(bus.flush), 0);
        check({tag, "_stall"}, int'(bus.stall_cycles), 0);
        check({tag, "_dec_ready"}, int'(bus.dec_ready), 1);
    endtask

    task automatic idle_inputs();
        bus.dec_valid = 0; bus.dec_type = '0; bus.dec_is_load = 0;
        bus.dec_rd = '0; bus.dec_rs1 = '0; bus.dec_rs2 = '0;
        bus.br_resolve = 0; bus.br_taken = 0; bus.lsu_done = 0;
        bus.wb_valid = 0; bus.wb_rd = '0;
    endtask

    task automatic random_inputs();
        logic [5:0] oh;
        cur_t = int'($urandom_range(0, 5));
        oh = 6'b100000;
        bus.dec_type    = oh >> cur_t;
        bus.dec_valid   = ($urandom_range(0, 3) != 0);
        bus.dec_is_load = 1'($urandom_range(0, 1));
        bus.dec_rd      = 5'($urandom_range(0, 7));
        bus.dec_rs1     = 5'($urandom_range(0, 7));
        bus.dec_rs2     = 5'($urandom_range(0, 7));
        bus.br_resolve  = ($urandom_range(0, 3) == 0);
        bus.br_taken    = 1'($urandom_range(0, 1));
        bus.lsu_done    = ($urandom_range(0, 3) == 0);
        bus.wb_valid    = ($urandom_range(0, 4) == 0);
        bus.wb_rd       = 5'($urandom_range(0, 7));
    endtask

    // Monitor: compares DUT outputs half a cycle after each edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("dec_ready", int'(bus.dec_ready), int'(m_ready()));
            check("flush", int'(bus.flush), int'(m_flush));
            check("stall_cycles", int'(bus.stall_cycles), m_stall);
            if (bus.exu_valid) begin
                issues_seen++;
                if (exp_q.size() == 0) begin
                    check("exu_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("issue %0d: sel=%03b rd=%0d at %0t", issues_seen, bus.exu_sel, bus.exu_rd, $time);
                    check("exu_sel", int'(bus.exu_sel), e.sel);
                    check("exu_rd", int'(bus.exu_rd), e.rd);
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("exu_missing", 0, 1);
            end
        end
    end

    initial begin
        model_reset();
        idle_inputs();
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        #2 rst = 0;
        for (int c = 0; c < CYCLES; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #2;
            end
            if (c > 0 && $urandom_range(0, 199) == 0) begin
                rst = 1;
                #1;
                check_reset_outputs("midrst");
                model_reset();
                idle_inputs();
                @(negedge clk);
                #2 rst = 0;
            end
            random_inputs();
            @(posedge clk);
            model_step();
        end
        @(negedge clk);
        #2;
        check("exp_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter STALL_W, default 16, width of the stall-cycle counter.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port dec_valid  input  1  decode offers an instruction.
REQ-005 SHALL have port dec_ready  output  1  scheduler accepts the offer this cycle.
REQ-006 SHALL have port dec_type  input  6  one-hot {r,i,s,b,u,j}, r in MSB.
REQ-007 SHALL have port dec_is_load  input  1  i-type is a load, not an ALU-immediate.
REQ-008 SHALL have ports dec_rd, dec_rs1, dec_rs2  input  5 each  register indices.
REQ-009 SHALL have port exu_valid  output  1  one-cycle issue pulse to Execute.
REQ-010 SHALL have port exu_sel  output  3  {en_alu,en_bu,en_lsu} for the issued instruction.
REQ-011 SHALL have port exu_rd  output  5  destination of the issued instruction.
REQ-012 SHALL have ports br_resolve, br_taken  input  1 each  branch outcome strobe and result.
REQ-013 SHALL have port lsu_done  input  1  load/store completion strobe.
REQ-014 SHALL have ports wb_valid, wb_rd  input  1, 5  register write-back retire.
REQ-015 SHALL have port flush  output  1  one-cycle pulse on taken branch.
REQ-016 SHALL have port stall_cycles  output  STALL_W  saturating count of hazard-stall cycles.

Function
REQ-017 SHALL hold one instruction in a single-entry buffer (buf_full flag).
REQ-018 SHALL drive dec_ready = (state==IDLE or WAIT states) and (!buf_full or can_issue); dec_ready SHALL be 0 in FLUSH.
REQ-019 SHALL load the buffer on dec_valid & dec_ready at the clock edge.
REQ-020 SHALL use sources: r,s,b use rs1 and rs2; i uses rs1; u,j use none.
REQ-021 SHALL write rd for r,i,u,j; never for s,b; never when rd==0.
REQ-022 SHALL keep a 32-bit busy scoreboard; bit 0 SHALL always read 0.
REQ-023 SHALL compute hazard = any used source with busy set; can_issue = buf_full & state==IDLE & !hazard.
REQ-024 SHALL on can_issue register exu_valid=1, exu_sel, exu_rd for exactly one cycle and clear buf_full, unless refilled that same edge.
REQ-025 SHALL map exu_sel: r, or i with !dec_is_load -> 100; b or j -> 010; s, or i with dec_is_load -> 001; u -> 000.
REQ-026 SHALL set busy[rd] on issue of a writing instruction; SHALL clear busy[wb_rd] on wb_valid; set SHALL win if both target the same index on one edge.
REQ-027 SHALL implement states IDLE, WAIT_BR, WAIT_LSU, FLUSH.
REQ-028 SHALL move IDLE->WAIT_BR on issuing b/j, IDLE->WAIT_LSU on issuing an LSU op, and otherwise stay IDLE.
REQ-029 SHALL move WAIT_LSU->IDLE on lsu_done.
REQ-030 SHALL move WAIT_BR->IDLE on br_resolve & !br_taken, and WAIT_BR->FLUSH on br_resolve & br_taken.
REQ-031 SHALL in FLUSH assert flush=1 for one cycle, clear buf_full, keep scoreboard, and return to IDLE next edge.
REQ-032 SHALL ignore br_resolve outside WAIT_BR and lsu_done outside WAIT_LSU.
REQ-033 SHALL increment stall_cycles each cycle buf_full & state==IDLE & hazard, saturating at all-ones.
REQ-034 SHALL register all outputs except dec_ready.

Reset
REQ-035 SHALL on rst, asynchronously, force state=IDLE, buf_full=0, busy=0, exu_valid=0, exu_sel=000, exu_rd=0, flush=0, stall_cycles=0.
REQ-036 SHALL discard any in-flight branch or LSU wait when rst asserts mid-operation; dec_ready SHALL be 1 in the first cycle after release.

Verification
REQ-037 Back-to-back ALU ops with rd=1,2 and no hazards -> exu_valid in consecutive cycles, exu_sel=100, busy[1], busy[2] set.
REQ-038 r-op rd=5 issued, then r-op rs1=5 -> stalled, stall_cycles increments per cycle; wb_valid wb_rd=5 -> issue on the next edge.
REQ-039 Branch issued, then br_resolve=1 br_taken=1 with a buffered instruction -> flush=1 for one cycle, buffer dropped, no exu_valid for it.
REQ-040 Load issued -> exu_sel=001, state WAIT_LSU, no issue until lsu_done; untaken br_resolve during the wait ignored.
REQ-041 wb_valid wb_rd=7 on the same edge as issue with rd=7 -> busy[7] remains 1; rd=0 issue -> busy[0] remains 0.
REQ-042 rst pulsed in WAIT_BR with busy nonzero -> all outputs zero, dec_ready=1 after release.
